concat_imm_s: RTL and testbench

//   Registered immediate assembler for the RISC-V datapath (S-type store offset).
//   - Joins a 5-bit low field (imm[4:0]) and a 7-bit high field (imm[11:5]) into a 12-bit immediate.
//   - Also provides a 32-bit extended copy for the ALU operand mux.
//   - Sits between instruction-field extraction and the immediate/operand select stage.

---
 rtl/concat_imm_s.sv | 68 ++++++
 tb/tb_concat_imm_s.sv | 138 +++++++++++++
 2 files changed

// File: rtl/concat_imm_s.sv
// Registered S-type immediate assembler: joins imm[4:0] and imm[11:5]
// into a 12-bit immediate plus a sign/zero-extended operand copy.
module concat_imm_s #(
  parameter int W_LO  = 5,
  parameter int W_HI  = 7,
  parameter int W_EXT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [W_LO-1:0]      Num_A,
  input  logic [W_HI-1:0]      Num_B,
  input  logic                 sext,
  output logic [W_LO+W_HI-1:0] Salida,
  output logic [W_EXT-1:0]     Salida_ext,
  output logic                 out_valid,
  output logic                 is_zero
);

  localparam int W_IMM = W_LO + W_HI;

  logic [W_IMM-1:0] imm;
  logic [W_EXT-1:0] imm_ext;

  logic [W_IMM-1:0] salida_d, salida_q;
  logic [W_EXT-1:0] ext_d, ext_q;
  logic             valid_d, valid_q;
  logic             zero_d, zero_q;

  always_comb begin
    imm     = {Num_B, Num_A};
    imm_ext = sext ? W_EXT'($signed(imm)) : W_EXT'(imm);
  end

  // Inputs only reach the datapath under in_valid, so idle X cannot leak.
  always_comb begin
    salida_d = salida_q;
    ext_d    = ext_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    if (in_valid) begin
      salida_d = imm;
      ext_d    = imm_ext;
      zero_d   = (imm == '0);
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      salida_q <= '0;
      ext_q    <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      salida_q <= salida_d;
      ext_q    <= ext_d;
      valid_q  <= valid_d;
      zero_q   <= zero_d;
    end
  end

  assign Salida     = salida_q;
  assign Salida_ext = ext_q;
  assign out_valid  = valid_q;
  assign is_zero    = zero_q;

endmodule

// File: tb/tb_concat_imm_s.sv
// Directed bench for concat_imm_s: reset, capture, extension,
// hold behaviour and mid-stream reset.
module tb_concat_imm_s;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  Num_A;
  logic [6:0]  Num_B;
  logic        sext;
  logic [11:0] Salida;
  logic [31:0] Salida_ext;
  logic        out_valid;
  logic        is_zero;

  int checks   = 0;
  int failures = 0;

  concat_imm_s dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .Num_A      (Num_A),
    .Num_B      (Num_B),
    .sext       (sext),
    .Salida     (Salida),
    .Salida_ext (Salida_ext),
    .out_valid  (out_valid),
    .is_zero    (is_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] a,
                       input logic [6:0] b, input logic s);
    in_valid = v;
    Num_A    = a;
    Num_B    = b;
    sext     = s;
  endtask

  task automatic chk_all(input string tag, input logic [11:0] s,
                         input logic [31:0] e, input logic v,
                         input logic z);
    chk({tag, ".salida"}, 32'(Salida), 32'(s));
    chk({tag, ".ext"}, Salida_ext, e);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".zero"}, 32'(is_zero), 32'(z));
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 7'd0, 1'b0);
    cyc();
    cyc();
    chk_all("reset", 12'h000, 32'h0, 1'b0, 1'b0);

    rst = 1'b0;
    drive(1'b1, 5'd0, 7'd0, 1'b0);
    cyc();
    chk_all("zero", 12'h000, 32'h0, 1'b1, 1'b1);

    drive(1'b1, 5'd15, 7'd87, 1'b1);
    cyc();
    chk_all("aef_s", 12'hAEF, 32'hFFFF_FAEF, 1'b1, 1'b0);

    drive(1'b1, 5'd15, 7'd87, 1'b0);
    cyc();
    chk_all("aef_z", 12'hAEF, 32'h0000_0AEF, 1'b1, 1'b0);

    drive(1'b1, 5'd4, 7'd127, 1'b1);
    cyc();
    chk_all("fe4", 12'hFE4, 32'hFFFF_FFE4, 1'b1, 1'b0);

    drive(1'b1, 5'd31, 7'd127, 1'b1);
    cyc();
    chk_all("ones_s", 12'hFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);

    drive(1'b1, 5'd31, 7'd127, 1'b0);
    cyc();
    chk_all("ones_z", 12'hFFF, 32'h0000_0FFF, 1'b1, 1'b0);

    drive(1'b1, 5'd15, 7'd87, 1'b1);
    cyc();
    chk_all("hold0", 12'hAEF, 32'hFFFF_FAEF, 1'b1, 1'b0);

    drive(1'b0, 5'd0, 7'd0, 1'b0);
    cyc();
    chk_all("hold1", 12'hAEF, 32'hFFFF_FAEF, 1'b0, 1'b0);

    drive(1'b0, 5'd31, 7'd3, 1'b1);
    cyc();
    chk_all("hold2", 12'hAEF, 32'hFFFF_FAEF, 1'b0, 1'b0);

    in_valid = 1'b0;
    Num_A    = 'x;
    Num_B    = 'x;
    sext     = 1'b0;
    cyc();
    chk_all("hold3", 12'hAEF, 32'hFFFF_FAEF, 1'b0, 1'b0);

    drive(1'b1, 5'd4, 7'd127, 1'b1);
    cyc();
    chk_all("b2b1", 12'hFE4, 32'hFFFF_FFE4, 1'b1, 1'b0);

    rst = 1'b1;
    drive(1'b1, 5'd15, 7'd87, 1'b1);
    cyc();
    chk_all("b2b_rst", 12'h000, 32'h0, 1'b0, 1'b0);

    rst = 1'b0;
    drive(1'b1, 5'd31, 7'd0, 1'b1);
    cyc();
    chk_all("b2b3", 12'h01F, 32'h0000_001F, 1'b1, 1'b0);

    drive(1'b0, 5'd0, 7'd0, 1'b0);
    cyc();
    chk_all("tail", 12'h01F, 32'h0000_001F, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
